// File: rtl/sm_rom_loader.sv
// Serial program loader: parses SYNC/LEN/data/CHK packets from a byte stream and
// writes little-endian 32-bit words into the instruction ROM, holding the CPU in reset while loading.
module sm_rom_loader #(
    parameter int unsigned SIZE = 64,
    parameter logic [7:0]  SYNC = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        rom_wr,
    output logic [31:0] rom_a,
    output logic [31:0] rom_wd,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CHK, ERR} state_t;

    localparam logic [16:0] SIZE_W = 17'(SIZE);

    state_t      state, state_nx;
    logic        accept;
    logic        wr_state;
    logic        boot;
    logic        sync_hit;
    logic [7:0]  len_lo;
    logic [15:0] n_len;
    logic [7:0]  acc;
    logic [23:0] word_lo;
    logic [1:0]  byte_idx;
    logic [15:0] len_full;
    logic        len_over;

    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len_lo};
    assign len_over = {1'b0, len_full} > SIZE_W;
    assign sync_hit = (state == IDLE) && accept && (in_data == SYNC);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b1;
        wr_state = 1'b0;
        case (state)
            IDLE:  if (sync_hit) state_nx = LEN0;
            LEN0:  if (accept) state_nx = LEN1;
            LEN1:  if (accept) begin
                       if (len_over)               state_nx = ERR;
                       else if (len_full == 16'd0) state_nx = CHK;
                       else                        state_nx = DATA;
                   end
            DATA:  if (accept && byte_idx == 2'd3) state_nx = WRITE;
            WRITE: begin
                       in_ready = 1'b0;
                       wr_state = 1'b1;
                       state_nx = (words + 16'd1 == n_len) ? CHK : DATA;
                   end
            CHK:   if (accept) state_nx = (in_data == acc) ? IDLE : ERR;
            ERR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Suppress a write that coincides with a reset edge.
        rom_wr = wr_state && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_a    <= '0;
            rom_wd   <= '0;
            cpu_rst  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            words    <= '0;
            boot     <= 1'b1;
            len_lo   <= '0;
            n_len    <= '0;
            acc      <= '0;
            word_lo  <= '0;
            byte_idx <= '0;
        end else begin
            done <= 1'b0;
            boot <= 1'b0;
            // The power-on program runs once reset is released, unless a load starts at once.
            if (boot && !sync_hit) cpu_rst <= 1'b0;
            case (state)
                IDLE: if (sync_hit) begin
                    busy    <= 1'b1;
                    cpu_rst <= 1'b1;
                    err     <= 1'b0;
                    words   <= '0;
                    acc     <= '0;
                end
                LEN0: if (accept) len_lo <= in_data;
                LEN1: if (accept) begin
                    n_len    <= len_full;
                    byte_idx <= '0;
                    if (len_over) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                DATA: if (accept) begin
                    acc      <= acc ^ in_data;
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: word_lo[7:0]   <= in_data;
                        2'd1: word_lo[15:8]  <= in_data;
                        2'd2: word_lo[23:16] <= in_data;
                        default: begin
                            rom_wd <= {in_data, word_lo};
                            rom_a  <= {16'b0, words};
                        end
                    endcase
                end
                WRITE: words <= words + 16'd1;
                CHK: if (accept) begin
                    busy <= 1'b0;
                    if (in_data == acc) begin
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_rom_loader.sv
// Self-checking bench for sm_rom_loader: table vectors, hand-written reset sequences,
// and a randomized packet stream checked against a packet-level reference parser.
module tb_sm_rom_loader;

    localparam int unsigned SIZE = 64;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, rom_wr, cpu_rst, busy, done, err;
    logic [31:0] rom_a, rom_wd;
    logic [15:0] words;

    always #5 clk = ~clk;

    sm_rom_loader #(.SIZE(SIZE), .SYNC(SYNC)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rom_wr(rom_wr), .rom_a(rom_a), .rom_wd(rom_wd), .cpu_rst(cpu_rst),
        .busy(busy), .done(done), .err(err), .words(words)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] wr_log[$];
    int          done_cnt = 0;
    int          consec_bad = 0;
    int          rdy_bad = 0;
    logic        prev_wr = 1'b0;

    // Reference model state
    logic [63:0] exp_wr[$];
    int          m_done = 0;
    logic        m_err = 1'b0;
    logic        m_cpu_rst = 1'b0;
    int          m_words = 0;

    typedef struct {
        logic [127:0] bytes;
        int           nb;
        int           nwr;
        logic [31:0]  last_a;
        logic [31:0]  last_wd;
        int           ndone;
        logic         err;
        logic         cpu_rst;
        logic [15:0]  words;
        int           maxgap;
    } vec_t;

    vec_t vt[7];

    initial begin
        forever begin
            @(negedge clk);
            if (rom_wr === 1'b1) begin
                wr_log.push_back({rom_a, rom_wd});
                if (prev_wr) consec_bad++;
            end
            prev_wr = (rom_wr === 1'b1);
            if (done === 1'b1) done_cnt++;
            if (!rst && (in_ready !== !rom_wr)) rdy_bad++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_log.delete();
        done_cnt = 0;
        consec_bad = 0;
        rdy_bad = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: in_ready low for %0d cycles, required high", t);
        end
        tick();
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int maxgap);
        int g;
        foreach (s[i]) begin
            send_byte(s[i]);
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (g > 0) begin
                in_valid = 1'b0;
                repeat (g) tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_rom_wr"},   64'(rom_wr),   64'd0);
        chk({tag, "_rom_a"},    64'(rom_a),    64'd0);
        chk({tag, "_rom_wd"},   64'(rom_wd),   64'd0);
        chk({tag, "_cpu_rst"},  64'(cpu_rst),  64'd1);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_err"},      64'(err),      64'd0);
        chk({tag, "_words"},    64'(words),    64'd0);
    endtask

    // Packet-level parser of a byte stream, following the framing rules directly.
    task automatic model_run(input logic [7:0] s[$]);
        int i = 0;
        int n;
        logic [7:0] x;
        while (i < s.size()) begin
            if (s[i] != SYNC) begin
                i++;
                continue;
            end
            i++;
            m_err = 1'b0;
            m_cpu_rst = 1'b1;
            m_words = 0;
            if (i + 2 > s.size()) break;
            n = {16'd0, s[i+1], s[i]};
            i += 2;
            if (n > int'(SIZE)) begin
                m_err = 1'b1;
                continue;
            end
            if (i + 4 * n + 1 > s.size()) break;
            x = 8'h00;
            for (int w = 0; w < n; w++) begin
                exp_wr.push_back({32'(w), s[i+3], s[i+2], s[i+1], s[i]});
                x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
                m_words = w + 1;
                i += 4;
            end
            if (s[i] == x) begin
                m_done++;
                m_cpu_rst = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            i++;
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        logic [7:0] x;
        int n, t, ng, lim;
        vec_t v;

        vt[0] = '{128'hA501001305100006, 8,  1, 32'd0, 32'h00100513, 1, 1'b0, 1'b0, 16'd1, 1};
        vt[1] = '{128'hA501001305100007, 8,  1, 32'd0, 32'h00100513, 0, 1'b1, 1'b1, 16'd1, 1};
        vt[2] = '{128'hA501001305100006, 8,  1, 32'd0, 32'h00100513, 1, 1'b0, 1'b0, 16'd1, 2};
        vt[3] = '{128'hA54100,           3,  0, 32'd0, 32'h0,        0, 1'b1, 1'b1, 16'd0, 1};
        vt[4] = '{128'hA5000000,         4,  0, 32'd0, 32'h0,        1, 1'b0, 1'b0, 16'd0, 1};
        vt[5] = '{128'h00FF13A50100A5A5000101, 11, 1, 32'd0, 32'h0100A5A5, 1, 1'b0, 1'b0, 16'd1, 1};
        vt[6] = '{128'hA503001122334455667788_99AABBCCCC, 16, 3, 32'd2, 32'hCCBBAA99, 1, 1'b0, 1'b0, 16'd3, 0};

        // Reset state, then release of the CPU one cycle after reset drops
        rst = 1'b1;
        tick();
        tick();
        check_reset_values("por");
        rst = 1'b0;
        tick();
        chk("por_cpu_rst_release", 64'(cpu_rst), 64'd0);

        // Table-driven packets, applied back to back so sticky state carries over
        for (int k = 0; k < 7; k++) begin
            v = vt[k];
            q.delete();
            for (int j = 0; j < v.nb; j++) q.push_back(v.bytes[8*(v.nb-1-j) +: 8]);
            clear_log();
            send_stream(q, v.maxgap);
            repeat (4) tick();
            chk($sformatf("vec%0d_nwr", k), 64'(wr_log.size()), 64'(v.nwr));
            if (v.nwr > 0 && wr_log.size() > 0)
                chk($sformatf("vec%0d_last_write", k), wr_log[wr_log.size()-1], {v.last_a, v.last_wd});
            if (v.nwr == 3 && wr_log.size() == 3) begin
                chk($sformatf("vec%0d_write0", k), wr_log[0], {32'd0, 32'h44332211});
                chk($sformatf("vec%0d_write1", k), wr_log[1], {32'd1, 32'h88776655});
            end
            chk($sformatf("vec%0d_done", k),    64'(done_cnt), 64'(v.ndone));
            chk($sformatf("vec%0d_err", k),     64'(err),      64'(v.err));
            chk($sformatf("vec%0d_cpu_rst", k), 64'(cpu_rst),  64'(v.cpu_rst));
            chk($sformatf("vec%0d_words", k),   64'(words),    64'(v.words));
            chk($sformatf("vec%0d_busy", k),    64'(busy),     64'd0);
            chk($sformatf("vec%0d_wr_pulse", k), 64'(consec_bad), 64'd0);
            chk($sformatf("vec%0d_ready_vs_wr", k), 64'(rdy_bad), 64'd0);
        end

        // Reset after 6 data bytes of an N=2 packet
        clear_log();
        q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_stream(q, 0);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        chk("midrst_nwr", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) chk("midrst_write0", wr_log[0], {32'd0, 32'h04030201});
        rst = 1'b0;
        tick();
        chk("midrst_cpu_rst_release", 64'(cpu_rst), 64'd0);
        repeat (3) tick();
        chk("midrst_no_late_write", 64'(wr_log.size()), 64'd1);
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_stream(q, 1);
        repeat (4) tick();
        chk("reload_nwr", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) chk("reload_write0", wr_log[0], {32'd0, 32'hEFBEADDE});
        chk("reload_done", 64'(done_cnt), 64'd1);
        chk("reload_cpu_rst", 64'(cpu_rst), 64'd0);
        chk("reload_words", 64'(words), 64'd1);

        // Randomized stream against the reference parser; first packet is exactly SIZE words
        do_reset();
        clear_log();
        exp_wr.delete();
        m_done = 0;
        m_err = 1'b0;
        m_cpu_rst = 1'b0;
        m_words = 0;
        q.delete();
        for (int p = 0; p < 20; p++) begin
            ng = int'($urandom_range(0, 3));
            repeat (ng) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                q.push_back(b);
            end
            t = (p == 0) ? 0 : int'($urandom_range(0, 3));
            if (t == 3) begin
                n = int'($urandom_range(SIZE + 1, 65535));
                q.push_back(SYNC);
                q.push_back(n[7:0]);
                q.push_back(n[15:8]);
            end else begin
                n = (p == 0) ? int'(SIZE) : int'($urandom_range(0, 6));
                q.push_back(SYNC);
                q.push_back(n[7:0]);
                q.push_back(n[15:8]);
                x = 8'h00;
                repeat (4 * n) begin
                    b = 8'($urandom_range(0, 255));
                    x ^= b;
                    q.push_back(b);
                end
                if (t == 2) x ^= 8'($urandom_range(1, 255));
                q.push_back(x);
            end
        end
        model_run(q);
        send_stream(q, 2);
        repeat (4) tick();
        chk("rand_nwr", 64'(wr_log.size()), 64'(exp_wr.size()));
        lim = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
        for (int k = 0; k < lim; k++) chk($sformatf("rand_write%0d", k), wr_log[k], exp_wr[k]);
        chk("rand_done", 64'(done_cnt), 64'(m_done));
        chk("rand_err", 64'(err), 64'(m_err));
        chk("rand_cpu_rst", 64'(cpu_rst), 64'(m_cpu_rst));
        chk("rand_words", 64'(words), 64'(m_words));
        chk("rand_busy", 64'(busy), 64'd0);
        chk("rand_wr_pulse", 64'(consec_bad), 64'd0);
        chk("rand_ready_vs_wr", 64'(rdy_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sm_rom_loader.md
Name: sm_rom_loader

Overview:
- Serial program loader that writes a program image into the instruction ROM's write port (wr / a / data_in) at runtime, replacing the power-on program.mem contents.
- Consumes a byte stream over a valid/ready handshake, typically from a UART receiver.
- Parses a framed packet, assembles little-endian 32-bit words and issues one ROM write per word.
- Holds the CPU in reset while loading and releases it only after a good checksum.

Parameters:
- SIZE, 64, ROM depth in words; a packet longer than this is rejected.
- SYNC, 8'hA5, start-of-packet byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts in_data this cycle
- rom_wr  out  1  ROM write strobe, one cycle per word
- rom_a  out  32  ROM word address
- rom_wd  out  32  ROM write data
- cpu_rst  out  1  CPU reset request
- busy  out  1  packet in progress
- done  out  1  one-cycle pulse on successful load
- err  out  1  sticky error flag
- words  out  16  count of words written in the current or last packet

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, rom_wr=0, rom_a=0, rom_wd=0, cpu_rst=1, busy=0, done=0, err=0, words=0.
- cpu_rst deasserts on the cycle after rst deasserts.
- Byte acceptance: a byte is accepted on a clk edge where in_valid && in_ready.
- in_ready is 1 in every state except WRITE. No combinational path from in_valid to in_ready.
- Packet format: SYNC, LEN_LO, LEN_HI, then 4*N data bytes (word i at byte offsets 4i..4i+3, LSB first), then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK = XOR of all data bytes; 8'h00 when N=0.
- IDLE:
  - Non-SYNC bytes are accepted and discarded.
  - SYNC byte: go to LEN0, set busy=1, cpu_rst=1, clear err, words=0, xor accumulator=0.
- LEN0: latch LEN_LO, go to LEN1.
- LEN1: latch LEN_HI, then
  - N > SIZE: go to ERR;
  - N == 0: go to CHK;
  - otherwise: go to DATA, byte index=0, word index=0.
- DATA:
  - Each accepted byte shifts into the word register at byte lane = index[1:0], and XORs into the accumulator.
  - On the 4th byte, go to WRITE.
- WRITE (exactly 1 cycle, in_ready=0):
  - rom_wr=1, rom_a=word index, rom_wd=assembled word.
  - words increments on the same edge.
  - If words+1 == N, go to CHK; else return to DATA.
- rom_a and rom_wd hold their last values while rom_wr=0. rom_wr is never high for more than one consecutive cycle.
- CHK:
  - Accepted byte == accumulator: done pulses 1 for one cycle, busy=0, cpu_rst=0, go to IDLE.
  - Otherwise: go to ERR.
- ERR (1 cycle): err=1 (sticky), busy=0, cpu_rst stays 1, go to IDLE.
- After an error, cpu_rst stays 1 until a later packet succeeds. Words already written are not rolled back.
- A SYNC byte in LEN0/LEN1/DATA/CHK is treated as ordinary data; there is no resynchronisation mid-packet.
- Bytes arriving in IDLE after a successful load do not affect cpu_rst unless they are SYNC.
- rst mid-packet:
  - Next cycle is IDLE with reset values; the partial packet is discarded.
  - No rom_wr is issued on or after the rst edge.
  - Words already written remain in the ROM.
- in_valid gaps of any length in any state are allowed; the state is held.

Test Plan:
- Reset, then packet A5 01 00 13 05 10 00 06 -> one rom_wr with rom_a=0 and rom_wd=32'h00100513; done pulses; cpu_rst falls; words=1; err=0.
- N=3 with back-to-back in_valid -> rom_wr at rom_a=0,1,2; in_ready=0 exactly in each WRITE cycle; no byte lost; correct CHK -> done.
- Same as the first scenario with CHK=07 -> 1 write occurs; err=1; done never pulses; cpu_rst stays 1. A following good packet -> err clears on SYNC, then done.
- LEN = 0x0041 with SIZE=64 -> ERR immediately after LEN_HI; no rom_wr; err=1. A N=0 packet A5 00 00 00 -> done with no writes.
- Garbage 00 FF 13 before SYNC -> ignored; no rom_wr. A5 appearing inside the data bytes -> written as data.
- rst asserted after 6 data bytes of an N=2 packet -> exactly 1 write occurred; all outputs at reset values next cycle; a new full packet loads correctly.
